dual_digit_display_ctrl: RTL and testbench

Sequencer that shares one registered hex-to-seven-segment lookup between the board's two digits. It accepts an 8-bit value on a load strobe and decodes the high nibble, then the low nibble, through the single lookup. It commits both patterns to the display at the same time. It also applies leading-zero blanking, an optional blink, and output polarity, and drives the segment pins directly.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/hex_seg_rom.sv | 19 +
 rtl/dual_digit_display_ctrl.sv | 118 +++++++++++
 tb/tb_dual_digit_display_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit seven-segment sequencer: lookup table,
// blank pattern and sequencer state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Active-high patterns, bit6..0 = GFEDCBA, indexed by nibble value.
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEC_HI = 2'd1,
    DEC_LO = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/hex_seg_rom.sv
// Registered hex-to-seven-segment lookup with one cycle of latency.
module hex_seg_rom
  import seg7_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_nibble,
  output logic [6:0] o_pattern
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pattern <= SEG_BLANK;
    end else begin
      o_pattern <= SEG_LUT[i_nibble];
    end
  end

endmodule

// File: rtl/dual_digit_display_ctrl.sv
// Two-digit display sequencer: decodes both nibbles through one shared lookup,
// commits them together, then applies blanking, blink and pin polarity.
module dual_digit_display_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned BLINK_DIV  = 12_500_000,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_value,
  input  logic       i_load,
  output logic       o_ready,
  input  logic       i_blink,
  output logic [6:0] o_dig1_seg,
  output logic [6:0] o_dig2_seg
);

  localparam int DIV_W = $clog2(BLINK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  function automatic logic [6:0] applyPol(input logic [6:0] x);
    return ACTIVE_LOW ? ~x : x;
  endfunction

  state_t           r_state;
  state_t           stateNext;
  logic [7:0]       r_value;
  logic [3:0]       romNibble;
  logic [6:0]       r_rom;
  logic [6:0]       r_hi_pat;
  logic [6:0]       r_disp1;
  logic [6:0]       r_disp2;
  logic [DIV_W-1:0] r_div;
  logic             r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= stateNext;
    end
  end

  always_comb begin
    stateNext = r_state;
    romNibble = r_value[3:0];
    o_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_load) stateNext = DEC_HI;
      end
      DEC_HI: begin
        romNibble = r_value[7:4];
        stateNext = DEC_LO;
      end
      DEC_LO:  stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  hex_seg_rom u_rom (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_nibble (romNibble),
    .o_pattern(r_rom)
  );

  // The high pattern is parked while the low nibble decodes, so both digit
  // registers can be written on the same edge and the display never tears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value  <= 8'h00;
      r_hi_pat <= SEG_BLANK;
      r_disp1  <= SEG_BLANK;
      r_disp2  <= SEG_BLANK;
    end else begin
      case (r_state)
        IDLE:   if (i_load) r_value <= i_value;
        DEC_LO: r_hi_pat <= r_rom;
        COMMIT: begin
          r_disp1 <= (BLANK_LZ && (r_value[7:4] == 4'h0)) ? SEG_BLANK : r_hi_pat;
          r_disp2 <= r_rom;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (!i_blink) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dig1_seg <= applyPol(SEG_BLANK);
      o_dig2_seg <= applyPol(SEG_BLANK);
    end else begin
      o_dig1_seg <= applyPol(r_phase ? SEG_BLANK : r_disp1);
      o_dig2_seg <= applyPol(r_phase ? SEG_BLANK : r_disp2);
    end
  end

endmodule

// File: tb/tb_dual_digit_display_ctrl.sv
// Directed bench for dual_digit_display_ctrl: three parameter variants driven
// in parallel, expected values from a scoreboard of loaded values.
module tb_dual_digit_display_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load, blink;
  logic [7:0] value;
  logic       readyA, readyB, readyC;
  logic [6:0] segA1, segA2, segB1, segB2, segC1, segC2;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sbQ[$];
  logic [7:0] lastV = 8'h00;
  logic [7:0] heldTbl [0:8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11};

  dual_digit_display_ctrl #(.BLINK_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load), .o_ready(readyA),
    .i_blink(blink), .o_dig1_seg(segA1), .o_dig2_seg(segA2));

  dual_digit_display_ctrl #(.BLINK_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load), .o_ready(readyB),
    .i_blink(blink), .o_dig1_seg(segB1), .o_dig2_seg(segB2));

  dual_digit_display_ctrl #(.BLINK_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dutC (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load), .o_ready(readyC),
    .i_blink(blink), .o_dig1_seg(segC1), .o_dig2_seg(segC2));

  function automatic logic [6:0] hexPat(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  function automatic logic [6:0] expSeg(input logic [7:0] v, input bit hi, input bit al,
                                        input bit blz, input bit dark);
    logic [6:0] p;
    p = hi ? hexPat(v[7:4]) : hexPat(v[3:0]);
    if (hi && blz && (v[7:4] == 4'h0)) p = 7'b0;
    if (dark) p = 7'b0;
    return al ? ~p : p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkDisp(input string tag, input logic [7:0] v, input bit dark);
    chk({tag, "_A1"}, segA1, expSeg(v, 1'b1, 1'b1, 1'b1, dark));
    chk({tag, "_A2"}, segA2, expSeg(v, 1'b0, 1'b1, 1'b1, dark));
    chk({tag, "_B1"}, segB1, expSeg(v, 1'b1, 1'b1, 1'b0, dark));
    chk({tag, "_B2"}, segB2, expSeg(v, 1'b0, 1'b1, 1'b0, dark));
    chk({tag, "_C1"}, segC1, expSeg(v, 1'b1, 1'b0, 1'b1, dark));
    chk({tag, "_C2"}, segC2, expSeg(v, 1'b0, 1'b0, 1'b1, dark));
  endtask

  task automatic chkReady(input string tag, input logic exp);
    chk({tag, "_rdyA"}, {6'b0, readyA}, {6'b0, exp});
    chk({tag, "_rdyC"}, {6'b0, readyC}, {6'b0, exp});
  endtask

  task automatic popDisp(input string tag);
    logic [7:0] v;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=pending_value", tag);
    end else begin
      v = sbQ.pop_front();
      lastV = v;
      chkDisp(tag, v, 1'b0);
    end
  endtask

  task automatic doLoad(input logic [7:0] v, input string tag);
    value = v;
    load  = 1'b1;
    sbQ.push_back(v);
    step();
    load  = 1'b0;
    value = ~v;
    chkReady({tag, "_n0"}, 1'b0);
    step();
    chkReady({tag, "_n1"}, 1'b0);
    step();
    chkReady({tag, "_n2"}, 1'b0);
    step();
    chkReady({tag, "_n3"}, 1'b1);
    step();
    popDisp(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    blink = 1'b0;
    value = 8'h00;
    repeat (3) step();
    chkDisp("reset", 8'h00, 1'b1);
    chkReady("reset", 1'b1);
    rst_n = 1'b1;
    step();

    doLoad(8'hA5, "loadA5");
    doLoad(8'h07, "load07");

    // Continuous load with a new value every cycle: only every fourth is taken.
    for (int i = 0; i < 9; i++) begin
      value = heldTbl[i];
      load  = 1'b1;
      if (i % 4 == 0) sbQ.push_back(heldTbl[i]);
      step();
      if (i == 3 || i == 7) chkDisp("noTear", lastV, 1'b0);
      if (i == 4 || i == 8) popDisp("held");
    end
    load = 1'b0;
    repeat (4) step();
    popDisp("heldLast");

    doLoad(8'hFF, "loadFF");

    doLoad(8'h88, "load88");
    blink = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      chkDisp("blink", 8'h88, (((k - 1) / 4) % 2) == 1);
    end
    blink = 1'b0;
    step();
    chkDisp("blinkOff0", 8'h88, 1'b1);
    step();
    chkDisp("blinkOff1", 8'h88, 1'b0);
    blink = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chkDisp("blinkRestart", 8'h88, k == 5);
    end
    blink = 1'b0;
    repeat (2) step();
    chkDisp("blinkEnd", 8'h88, 1'b0);

    // Reset lands while the 3C load is in DEC_LO.
    value = 8'h3C;
    load  = 1'b1;
    step();
    load  = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chkDisp("midReset", 8'h00, 1'b1);
    chkReady("midReset", 1'b1);
    #2;
    rst_n = 1'b1;
    doLoad(8'h21, "afterReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
